ls_reg_arb: RTL and testbench

LS_REG_ARB -- requirements
Module: ls_reg_arb

---
 rtl/ls_reg_arb_if.sv | 30 +++
 rtl/ls_reg_arb.sv | 141 ++++++++++++++
 tb/tb_ls_reg_arb.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ls_reg_arb_if.sv
// Bundle of requester handshakes and the four-register control bus for ls_reg_arb.
// The slave modport is the arbiter's view; master is the environment (requesters + registers).
interface ls_reg_arb_if;
  logic        req0;
  logic        req1;
  logic [1:0]  op0;
  logic [1:0]  op1;
  logic [1:0]  addr0;
  logic [1:0]  addr1;
  logic [3:0]  data0;
  logic [3:0]  data1;
  logic [15:0] reg_q;
  logic [3:0]  reg_set;
  logic [3:0]  reg_clr_n;
  logic [3:0]  reg_in;
  logic        ack0;
  logic        ack1;
  logic [3:0]  rdata;
  logic        busy;

  modport slave (
    input  req0, req1, op0, op1, addr0, addr1, data0, data1, reg_q,
    output reg_set, reg_clr_n, reg_in, ack0, ack1, rdata, busy
  );

  modport master (
    output req0, req1, op0, op1, addr0, addr1, data0, data1, reg_q,
    input  reg_set, reg_clr_n, reg_in, ack0, ack1, rdata, busy
  );
endinterface

// File: rtl/ls_reg_arb.sv
// Two-requester round-robin arbiter driving set/clear/data lines of four 4-bit registers.
// Each operation takes IDLE -> ISSUE -> ACK; all register control and acks are registered.
module ls_reg_arb (
  input logic         clk,
  input logic         rst,
  ls_reg_arb_if.slave bus
);

  typedef enum logic [1:0] {
    OpRead     = 2'b00,
    OpWrite    = 2'b01,
    OpClear    = 2'b10,
    OpClearAll = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StAck
  } state_e;

  state_e     state_q, state_d;
  logic       prio_q, prio_d;
  logic       gnt_q, gnt_d;
  logic [1:0] op_q, op_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] reg_set_q, reg_set_d;
  logic [3:0] reg_clr_n_q, reg_clr_n_d;
  logic [3:0] reg_in_q, reg_in_d;
  logic [3:0] rdata_q, rdata_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;

  logic       sel;
  logic [1:0] sel_op;
  logic [1:0] sel_addr;
  logic [3:0] sel_data;
  logic [3:0] rd_word;

  // Contention follows the pointer; a lone requester wins regardless of it.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      sel = prio_q;
    end else begin
      sel = bus.req1;
    end
    sel_op   = sel ? bus.op1   : bus.op0;
    sel_addr = sel ? bus.addr1 : bus.addr0;
    sel_data = sel ? bus.data1 : bus.data0;
  end

  assign rd_word = bus.reg_q[{addr_q, 2'b00} +: 4];

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    reg_set_d   = 4'b0000;
    reg_clr_n_d = 4'b1111;
    reg_in_d    = 4'b0000;
    rdata_d     = rdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          state_d = StIssue;
          gnt_d   = sel;
          prio_d  = ~sel;
          op_d    = sel_op;
          addr_d  = sel_addr;
          // Control lines are set up here so they are valid for the whole ISSUE cycle.
          unique case (op_e'(sel_op))
            OpRead:     ;
            OpWrite: begin
              reg_set_d[sel_addr] = 1'b1;
              reg_in_d            = sel_data;
            end
            OpClear:    reg_clr_n_d[sel_addr] = 1'b0;
            OpClearAll: reg_clr_n_d = 4'b0000;
            default:    ;
          endcase
        end
      end
      StIssue: begin
        state_d = StAck;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        if (op_e'(op_q) == OpRead) begin
          rdata_d = rd_word;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      gnt_q       <= 1'b0;
      op_q        <= 2'b00;
      addr_q      <= 2'b00;
      reg_set_q   <= 4'b0000;
      reg_clr_n_q <= 4'b1111;
      reg_in_q    <= 4'b0000;
      rdata_q     <= 4'b0000;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      reg_set_q   <= reg_set_d;
      reg_clr_n_q <= reg_clr_n_d;
      reg_in_q    <= reg_in_d;
      rdata_q     <= rdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
    end
  end

  assign bus.reg_set   = reg_set_q;
  assign bus.reg_clr_n = reg_clr_n_q;
  assign bus.reg_in    = reg_in_q;
  assign bus.rdata     = rdata_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ls_reg_arb.sv
// Bench for ls_reg_arb: models the four registers, queues expected acks/rdata per operation
// and pops them when an ack appears; directed checks cover ISSUE drive and reset cases.
module tb_ls_reg_arb;

  localparam logic [1:0] OpRead     = 2'b00;
  localparam logic [1:0] OpWrite    = 2'b01;
  localparam logic [1:0] OpClear    = 2'b10;
  localparam logic [1:0] OpClearAll = 2'b11;

  typedef struct packed {
    logic       who;
    logic [3:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t       sb[$];
  logic [3:0] regs [4];
  logic [3:0] shadow [4];
  logic [3:0] last_rdata;

  ls_reg_arb_if bus ();

  ls_reg_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register model: clear dominates, set loads, otherwise hold. Not affected by arbiter reset.
  initial for (int i = 0; i < 4; i++) regs[i] = 4'h0;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!bus.reg_clr_n[i]) regs[i] <= 4'h0;
      else if (bus.reg_set[i]) regs[i] <= bus.reg_in;
    end
  end
  assign bus.reg_q = {regs[3], regs[2], regs[1], regs[0]};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.ack0 || bus.ack1)) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {14'd0, bus.ack1, bus.ack0}, 16'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_who", {14'd0, bus.ack1, bus.ack0}, e.who ? 16'd2 : 16'd1);
        check("ack_rdata", {12'd0, bus.rdata}, {12'd0, e.rdata});
      end
    end
  end

  // Apply the op's effect to the shadow and queue the expected ack.
  task automatic expect_op(input logic who, input logic [1:0] op, input logic [1:0] addr,
                           input logic [3:0] data);
    exp_t e;
    e.who = who;
    case (op)
      OpRead:     last_rdata = shadow[addr];
      OpWrite:    shadow[addr] = data;
      OpClear:    shadow[addr] = 4'h0;
      default:    for (int i = 0; i < 4; i++) shadow[i] = 4'h0;
    endcase
    e.rdata = last_rdata;
    sb.push_back(e);
  endtask

  task automatic drive(input logic who, input logic [1:0] op, input logic [1:0] addr,
                       input logic [3:0] data);
    if (who) begin
      bus.req1 = 1'b1; bus.op1 = op; bus.addr1 = addr; bus.data1 = data;
    end else begin
      bus.req0 = 1'b1; bus.op0 = op; bus.addr0 = addr; bus.data0 = data;
    end
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!(bus.ack0 || bus.ack1) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(tag, {15'd0, bus.ack0 || bus.ack1}, 16'd1);
  endtask

  task automatic do_op(input logic who, input logic [1:0] op, input logic [1:0] addr,
                       input logic [3:0] data, input string tag);
    logic [3:0] e_set, e_clr, e_in;
    e_set = 4'b0000; e_clr = 4'b1111; e_in = 4'b0000;
    case (op)
      OpWrite:    begin e_set[addr] = 1'b1; e_in = data; end
      OpClear:    e_clr[addr] = 1'b0;
      OpClearAll: e_clr = 4'b0000;
      default:    ;
    endcase
    expect_op(who, op, addr, data);
    @(negedge clk);
    drive(who, op, addr, data);
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check({tag, "_busy"}, {15'd0, bus.busy}, 16'd1);
    check({tag, "_set"}, {12'd0, bus.reg_set}, {12'd0, e_set});
    check({tag, "_clr_n"}, {12'd0, bus.reg_clr_n}, {12'd0, e_clr});
    check({tag, "_in"}, {12'd0, bus.reg_in}, {12'd0, e_in});
    wait_ack({tag, "_ack"});
    @(negedge clk);
    check({tag, "_regs"}, bus.reg_q, {shadow[3], shadow[2], shadow[1], shadow[0]});
  endtask

  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.data0 = 0; bus.data1 = 0;
    for (int i = 0; i < 4; i++) shadow[i] = 4'h0;
    last_rdata = 4'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_set", {12'd0, bus.reg_set}, 16'h0000);
    check("rst_clr_n", {12'd0, bus.reg_clr_n}, 16'h000f);
    check("rst_in", {12'd0, bus.reg_in}, 16'h0000);
    check("rst_acks_busy", {13'd0, bus.ack1, bus.ack0, bus.busy}, 16'd0);
    check("rst_rdata", {12'd0, bus.rdata}, 16'h0000);
    rst = 1'b0;

    do_op(1'b0, OpWrite, 2'd2, 4'b1010, "wr0");
    do_op(1'b1, OpRead,  2'd2, 4'h0,    "rd1");

    // Both requesters held: grants must alternate starting with 0.
    begin
      int acks = 0;
      int n = 0;
      expect_op(1'b0, OpWrite, 2'd0, 4'h5);
      expect_op(1'b1, OpWrite, 2'd1, 4'h9);
      expect_op(1'b0, OpWrite, 2'd0, 4'h5);
      expect_op(1'b1, OpWrite, 2'd1, 4'h9);
      @(negedge clk);
      drive(1'b0, OpWrite, 2'd0, 4'h5);
      drive(1'b1, OpWrite, 2'd1, 4'h9);
      while (acks < 4 && n < 40) begin
        @(negedge clk);
        n++;
        if (bus.ack0 || bus.ack1) begin
          acks++;
          if (acks == 4) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
          end
          @(negedge clk);
          check("cont_ack_single", {14'd0, bus.ack1, bus.ack0}, 16'd0);
          check("cont_busy_gap", {15'd0, bus.busy}, 16'd0);
        end
      end
      check("cont_ack_count", acks[15:0], 16'd4);
      check("cont_regs", bus.reg_q, {shadow[3], shadow[2], shadow[1], shadow[0]});
    end

    do_op(1'b0, OpRead,     2'd0, 4'h0, "rd0_a0");
    do_op(1'b1, OpRead,     2'd1, 4'h0, "rd1_a1");
    do_op(1'b0, OpClear,    2'd2, 4'h0, "clr2");
    do_op(1'b1, OpRead,     2'd2, 4'h0, "rd_clr2");
    do_op(1'b1, OpClearAll, 2'd0, 4'h0, "clrall");
    do_op(1'b0, OpRead,     2'd1, 4'h0, "rd_after_clrall");
    do_op(1'b0, OpWrite,    2'd3, 4'h7, "wr3");
    do_op(1'b1, OpRead,     2'd3, 4'h0, "rd3");

    // Reset in ACK: the registered ack is visible but rdata/busy/ack all clear at the edge.
    @(negedge clk);
    drive(1'b1, OpRead, 2'd3, 4'h0);
    @(posedge clk);
    #1;
    bus.req1 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("ackrst_in_ack", {14'd0, bus.ack1, bus.ack0}, 16'd2);
    @(posedge clk);
    #1;
    check("ackrst_acks_busy", {13'd0, bus.ack1, bus.ack0, bus.busy}, 16'd0);
    check("ackrst_rdata", {12'd0, bus.rdata}, 16'h0000);
    @(posedge clk);
    #1;
    check("ackrst_hold", {bus.ack1, bus.ack0, bus.busy, bus.rdata, bus.reg_set, bus.reg_clr_n},
          16'h000f);
    rst = 1'b0;
    last_rdata = 4'h0;

    // Reset in ISSUE: the write still lands, no ack follows.
    @(negedge clk);
    drive(1'b0, OpWrite, 2'd1, 4'h3);
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    shadow[1] = 4'h3;
    check("issrst_reg1", {12'd0, bus.reg_q[7:4]}, 16'h0003);
    check("issrst_acks_busy", {13'd0, bus.ack1, bus.ack0, bus.busy}, 16'd0);
    repeat (4) @(negedge clk);

    // After reset the pointer is back at requester 0.
    expect_op(1'b0, OpRead, 2'd1, 4'h0);
    @(negedge clk);
    drive(1'b0, OpRead, 2'd1, 4'h0);
    drive(1'b1, OpRead, 2'd1, 4'h0);
    @(posedge clk);
    #1;
    wait_ack("post_rst_ack");
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) @(negedge clk);

    check("sb_empty", sb.size(), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
